// File: rtl/lcd_bus_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lcd_bus_ctrl_if
// Purpose  : Bundles the host write handshake and the HD44780 pin bus of
//            lcd_bus_ctrl.
// Ports    : start/cs/rs/nib/data  host -> controller write request
//            busy/done             controller -> host status
//            lcd_rs/lcd_rw/lcd_e/lcd_data  controller -> LCD pins
// Modports : master = host side (sequencer / testbench)
//            slave  = controller side (lcd_bus_ctrl)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface lcd_bus_ctrl_if;
   logic       start;
   logic       cs;
   logic       rs;
   logic       nib;
   logic [7:0] data;
   logic       busy;
   logic       done;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic [7:0] lcd_data;

   modport master (
      output start, cs, rs, nib, data,
      input  busy, done, lcd_rs, lcd_rw, lcd_e, lcd_data
   );

   modport slave (
      input  start, cs, rs, nib, data,
      output busy, done, lcd_rs, lcd_rw, lcd_e, lcd_data
   );
endinterface
`default_nettype wire

// File: rtl/lcd_bus_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lcd_bus_ctrl
// Purpose  : HD44780-style character-LCD write engine. Accepts one command or
//            data byte per start&cs handshake, drives the LCD pins in 8-bit or
//            4-bit (nibble) mode with parametrised setup / pulse / hold / gap
//            timing, then waits out the command execution time itself before
//            pulsing done.
// Ports    : clk    system clock
//            rst_n  asynchronous active-low reset
//            bus    lcd_bus_ctrl_if.slave (host handshake + LCD pins)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module lcd_bus_ctrl #(
   parameter int BUS4        = 0,
   parameter int T_SETUP     = 3,
   parameter int T_PW        = 12,
   parameter int T_HOLD      = 1,
   parameter int T_GAP       = 25,
   parameter int T_EXEC      = 2000,
   parameter int T_EXEC_LONG = 82000,
   parameter int CNT_W       = 17
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   lcd_bus_ctrl_if.slave bus
);

   localparam bit c_BUS4 = (BUS4 != 0);

   // Counter reload values: each timed state lasts (load + 1) cycles.
   localparam logic [CNT_W-1:0] c_LD_SETUP     = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] c_LD_PW        = CNT_W'(T_PW - 1);
   localparam logic [CNT_W-1:0] c_LD_HOLD      = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] c_LD_GAP       = CNT_W'(T_GAP - 1);
   localparam logic [CNT_W-1:0] c_LD_EXEC      = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] c_LD_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_EHIGH = 3'd2,
      S_HOLD  = 3'd3,
      S_GAP   = 3'd4,
      S_EXEC  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t           r_state,    w_state_nxt;
   logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
   logic             r_rs,       w_rs_nxt;
   logic [7:0]       r_data,     w_data_nxt;
   logic             r_nib,      w_nib_nxt;
   logic             r_second,   w_second_nxt;
   logic             r_lcd_e,    w_lcd_e_nxt;
   logic [7:0]       r_lcd_data, w_lcd_data_nxt;
   logic             r_busy,     w_busy_nxt;
   logic             r_done,     w_done_nxt;

   logic             w_cnt_zero;
   logic             w_exec_long;

   assign w_cnt_zero  = (r_cnt == '0);
   // Clear (0x01) and home (0x02/0x03) need the long wait; a lone nibble
   // never forms one of those commands, so it always gets the short wait.
   assign w_exec_long = !r_rs && (r_data[7:2] == 6'd0) && !r_nib;

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
      w_rs_nxt       = r_rs;
      w_data_nxt     = r_data;
      w_nib_nxt      = r_nib;
      w_second_nxt   = r_second;
      w_lcd_e_nxt    = 1'b0;
      w_lcd_data_nxt = r_lcd_data;

      case (r_state)
         S_IDLE: begin
            if (bus.start && bus.cs) begin
               w_rs_nxt       = bus.rs;
               w_data_nxt     = bus.data;
               w_nib_nxt      = c_BUS4 & bus.nib;
               w_second_nxt   = 1'b0;
               w_lcd_data_nxt = c_BUS4 ? {bus.data[7:4], 4'h0} : bus.data;
               w_state_nxt    = S_SETUP;
               w_cnt_nxt      = c_LD_SETUP;
            end
         end
         S_SETUP: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_EHIGH;
               w_cnt_nxt   = c_LD_PW;
               w_lcd_e_nxt = 1'b1;
            end
         end
         S_EHIGH: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = c_LD_HOLD;
            end else begin
               w_lcd_e_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (w_cnt_zero) begin
               if (c_BUS4 && !r_second && !r_nib) begin
                  // Bus only moves once the hold time after E fell is over.
                  w_state_nxt    = S_GAP;
                  w_cnt_nxt      = c_LD_GAP;
                  w_second_nxt   = 1'b1;
                  w_lcd_data_nxt = {r_data[3:0], 4'h0};
               end else begin
                  w_state_nxt = S_EXEC;
                  w_cnt_nxt   = w_exec_long ? c_LD_EXEC_LONG : c_LD_EXEC;
               end
            end
         end
         S_GAP: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_SETUP;
               w_cnt_nxt   = c_LD_SETUP;
            end
         end
         S_EXEC: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // Status flags are registered from the next state so they line up
      // with the state they describe.
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_rs       <= 1'b0;
         r_data     <= 8'h00;
         r_nib      <= 1'b0;
         r_second   <= 1'b0;
         r_lcd_e    <= 1'b0;
         r_lcd_data <= 8'h00;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_rs       <= w_rs_nxt;
         r_data     <= w_data_nxt;
         r_nib      <= w_nib_nxt;
         r_second   <= w_second_nxt;
         r_lcd_e    <= w_lcd_e_nxt;
         r_lcd_data <= w_lcd_data_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.lcd_rs   = r_rs;
   assign bus.lcd_rw   = 1'b0;
   assign bus.lcd_e    = r_lcd_e;
   assign bus.lcd_data = r_lcd_data;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_lcd_bus_ctrl
// Purpose  : Self-checking bench for lcd_bus_ctrl. One 8-bit and one 4-bit
//            instance share clock and reset. Each write pushes its expected
//            E pulses and done cycle to queues; a monitor pops and compares
//            them when the DUT produces them.
// Ports    : none
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_lcd_bus_ctrl;

   localparam int TS  = 3;
   localparam int TP  = 4;
   localparam int TH  = 1;
   localparam int TG  = 2;
   localparam int TX  = 5;
   localparam int TXL = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lcd_bus_ctrl_if if8 ();
   lcd_bus_ctrl_if if4 ();

   lcd_bus_ctrl #(
      .BUS4(0), .T_SETUP(TS), .T_PW(TP), .T_HOLD(TH), .T_GAP(TG),
      .T_EXEC(TX), .T_EXEC_LONG(TXL), .CNT_W(17)
   ) u_dut8 (
      .clk(clk), .rst_n(rst_n), .bus(if8)
   );

   lcd_bus_ctrl #(
      .BUS4(1), .T_SETUP(TS), .T_PW(TP), .T_HOLD(TH), .T_GAP(TG),
      .T_EXEC(TX), .T_EXEC_LONG(TXL), .CNT_W(17)
   ) u_dut4 (
      .clk(clk), .rst_n(rst_n), .bus(if4)
   );

   typedef struct {
      int         dut;
      int         rise;
      logic [7:0] d;
      logic       rs;
   } pulse_t;

   typedef struct {
      int dut;
      int cyc;
   } done_t;

   pulse_t q_p[$];
   done_t  q_done[$];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Per-instance views so the monitor can loop over both DUTs.
   logic       m_e[2];
   logic [7:0] m_d[2];
   logic       m_rs[2];
   logic       m_done[2];
   assign m_e[0] = if8.lcd_e;       assign m_e[1] = if4.lcd_e;
   assign m_d[0] = if8.lcd_data;    assign m_d[1] = if4.lcd_data;
   assign m_rs[0] = if8.lcd_rs;     assign m_rs[1] = if4.lcd_rs;
   assign m_done[0] = if8.done;     assign m_done[1] = if4.done;

   logic       prev_e[2];
   int         hi_cnt[2];
   logic [7:0] cur_d[2];
   logic       cur_rs[2];
   pulse_t     mp;
   done_t      md;

   initial begin
      prev_e[0] = 1'b0; prev_e[1] = 1'b0;
      hi_cnt[0] = 0;    hi_cnt[1] = 0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            prev_e[k] = 1'b0;
            hi_cnt[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_e[k] && !prev_e[k]) begin
               if (q_p.size() == 0) begin
                  check_val("unexpected_e_pulse", 1, 0);
                  cur_d[k]  = m_d[k];
                  cur_rs[k] = m_rs[k];
               end else begin
                  mp = q_p.pop_front();
                  check_val("e_dut", k, mp.dut);
                  check_val("e_rise_cycle", cyc, mp.rise);
                  check_val("e_data", {24'h0, m_d[k]}, {24'h0, mp.d});
                  check_val("e_rs", {31'h0, m_rs[k]}, {31'h0, mp.rs});
                  cur_d[k]  = mp.d;
                  cur_rs[k] = mp.rs;
               end
               hi_cnt[k] = 1;
            end else if (m_e[k]) begin
               hi_cnt[k]++;
               check_val("e_data_stable", {24'h0, m_d[k]}, {24'h0, cur_d[k]});
               check_val("e_rs_stable", {31'h0, m_rs[k]}, {31'h0, cur_rs[k]});
            end else if (prev_e[k]) begin
               check_val("e_width", hi_cnt[k], TP);
               check_val("hold_data", {24'h0, m_d[k]}, {24'h0, cur_d[k]});
               check_val("hold_rs", {31'h0, m_rs[k]}, {31'h0, cur_rs[k]});
            end
            prev_e[k] = m_e[k];

            if (m_done[k]) begin
               if (q_done.size() == 0) begin
                  check_val("unexpected_done", 1, 0);
               end else begin
                  md = q_done.pop_front();
                  check_val("done_dut", k, md.dut);
                  check_val("done_cycle", cyc, md.cyc);
               end
            end
         end
      end
   end

   function automatic logic busy_of(input int k);
      return (k == 0) ? if8.busy : if4.busy;
   endfunction

   task automatic drive(input int k, input logic st, input logic c, input logic r,
                        input logic n, input logic [7:0] d);
      if (k == 0) begin
         if8.start = st; if8.cs = c; if8.rs = r; if8.nib = n; if8.data = d;
      end else begin
         if4.start = st; if4.cs = c; if4.rs = r; if4.nib = n; if4.data = d;
      end
   endtask

   // Waits for IDLE, queues the expected pulses/done, then raises start.
   task automatic send(input int k, input logic r, input logic [7:0] d,
                       input logic n, input bit hold);
      int     a;
      int     last_rise;
      int     ex;
      int     guard;
      pulse_t p;
      done_t  dn;
      guard = 0;
      @(negedge clk);
      while (busy_of(k) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) check_val("idle_wait_timeout", 1, 0);
      a  = cyc + 1;
      ex = (!r && d[7:2] == 6'd0 && !(k == 1 && n)) ? TXL : TX;
      p.dut  = k;
      p.rs   = r;
      p.rise = a + TS;
      p.d    = (k == 0) ? d : {d[7:4], 4'h0};
      q_p.push_back(p);
      last_rise = a + TS;
      if (k == 1 && !n) begin
         p.rise = a + 2*TS + TP + TH + TG;
         p.d    = {d[3:0], 4'h0};
         q_p.push_back(p);
         last_rise = p.rise;
      end
      dn.dut = k;
      dn.cyc = last_rise + TP + TH + ex;
      q_done.push_back(dn);
      drive(k, 1'b1, 1'b1, r, n, d);
      @(negedge clk);
      check_val("busy_after_accept", {31'h0, busy_of(k)}, 1);
      // Scramble the inputs: the DUT must keep what it latched.
      if (!hold) drive(k, 1'b0, 1'b0, ~r, n, ~d);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((q_p.size() != 0 || q_done.size() != 0) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) check_val("drain_timeout", q_p.size() + q_done.size(), 0);
      repeat (5) @(negedge clk);
   endtask

   task automatic check_zero(input int k, input string tag);
      if (k == 0) begin
         check_val({tag, "_e8"},    {31'h0, if8.lcd_e},    0);
         check_val({tag, "_data8"}, {24'h0, if8.lcd_data}, 0);
         check_val({tag, "_rs8"},   {31'h0, if8.lcd_rs},   0);
         check_val({tag, "_rw8"},   {31'h0, if8.lcd_rw},   0);
         check_val({tag, "_busy8"}, {31'h0, if8.busy},     0);
         check_val({tag, "_done8"}, {31'h0, if8.done},     0);
      end else begin
         check_val({tag, "_e4"},    {31'h0, if4.lcd_e},    0);
         check_val({tag, "_data4"}, {24'h0, if4.lcd_data}, 0);
         check_val({tag, "_rs4"},   {31'h0, if4.lcd_rs},   0);
         check_val({tag, "_rw4"},   {31'h0, if4.lcd_rw},   0);
         check_val({tag, "_busy4"}, {31'h0, if4.busy},     0);
         check_val({tag, "_done4"}, {31'h0, if4.done},     0);
      end
   endtask

   initial begin
      int guard;
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero(0, "reset");
      check_zero(1, "reset");
      #2 rst_n = 1'b1;

      // 8-bit writes: data, clear (long), display control (short),
      // home with nib set (nib ignored in 8-bit mode), back-to-back.
      send(0, 1'b1, 8'h59, 1'b0, 1'b0); drain();
      send(0, 1'b0, 8'h01, 1'b0, 1'b0); drain();
      send(0, 1'b0, 8'h0C, 1'b0, 1'b0); drain();
      send(0, 1'b0, 8'h02, 1'b1, 1'b0); drain();
      send(0, 1'b1, 8'h41, 1'b0, 1'b0);
      send(0, 1'b1, 8'h42, 1'b0, 1'b0); drain();

      // 4-bit writes: full byte, single nibble, clear as two nibbles,
      // single nibble with a clear-like value (short wait).
      send(1, 1'b1, 8'h4E, 1'b0, 1'b0); drain();
      send(1, 1'b1, 8'h30, 1'b1, 1'b0); drain();
      send(1, 1'b0, 8'h01, 1'b0, 1'b0); drain();
      send(1, 1'b0, 8'h01, 1'b1, 1'b0); drain();

      // start held high throughout busy, then CS dropped in IDLE.
      send(0, 1'b1, 8'h33, 1'b0, 1'b1);
      guard = 0;
      while (!if8.done && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check_val("held_done_timeout", 1, 0);
      drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
      repeat (15) @(negedge clk);
      check_val("cs_low_no_accept", {31'h0, if8.busy}, 0);
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      drain();

      // Reset while E is high aborts the write asynchronously.
      send(0, 1'b1, 8'h59, 1'b0, 1'b0);
      guard = 0;
      while (!if8.lcd_e && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) check_val("e_wait_timeout", 1, 0);
      #2 rst_n = 1'b0;
      #1 check_zero(0, "async_reset");
      q_p.delete();
      q_done.delete();
      repeat (3) @(negedge clk);
      check_zero(0, "in_reset");
      #2 rst_n = 1'b1;
      send(0, 1'b1, 8'h59, 1'b0, 1'b0); drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
